barrett_modmul_ctrl: RTL and testbench

//   Sequencer for one modular multiply r = (a*b) mod q using Barrett reduction.

---
 rtl/barrett_pkg.sv | 16 +
 rtl/barrett_cfg_regs.sv | 54 +++++
 rtl/barrett_modmul_ctrl.sv | 143 ++++++++++++++
 tb/tb_barrett_modmul_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared types and defaults for the Barrett modular-multiply sequencer.
package barrett_pkg;

  localparam int unsigned W_DEF       = 64;
  localparam int unsigned MAXCORR_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    MUL_AB,
    MUL_MU,
    MUL_Q,
    CORR,
    DONE
  } state_e;

endpackage

// File: rtl/barrett_cfg_regs.sv
// Modulus configuration storage (q, mu, k) with a legality check on every write.
module barrett_cfg_regs import barrett_pkg::*; #(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] cfg_q,
  input  logic [W-1:0] cfg_mu,
  input  logic [7:0]   cfg_k,
  output logic [W-1:0] q,
  output logic [W-1:0] mu,
  output logic [7:0]   k,
  output logic         cfg_ok,
  output logic         cfg_err
);

  logic         legal;
  logic [W-1:0] q_top;

  // Legal when 1 <= k <= W-1 and q >> (k-1) == 1, i.e. bit k-1 is the top set bit.
  // This also rejects q == 0.
  always_comb begin
    q_top = '0;
    legal = 1'b0;
    if ((cfg_k != 8'd0) && (32'(cfg_k) <= (W - 1))) begin
      q_top = cfg_q >> (cfg_k - 8'd1);
      legal = (q_top == W'(1));
    end
  end

  // Store on a legal write; an illegal write drops cfg_ok and leaves old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      mu      <= '0;
      k       <= '0;
      cfg_ok  <= 1'b0;
      cfg_err <= 1'b0;
    end else if (we) begin
      if (legal) begin
        q       <= cfg_q;
        mu      <= cfg_mu;
        k       <= cfg_k;
        cfg_ok  <= 1'b1;
        cfg_err <= 1'b0;
      end else begin
        cfg_ok  <= 1'b0;
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrett_modmul_ctrl.sv
// Barrett modular multiply sequencer driving one shared external WxW multiplier.
module barrett_modmul_ctrl import barrett_pkg::*; #(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned MAXCORR = MAXCORR_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [W-1:0]   cfg_q,
  input  logic [W-1:0]   cfg_mu,
  input  logic [7:0]     cfg_k,
  output logic           cfg_ok,
  output logic           cfg_err,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_r,
  output logic           out_err,
  output logic           mul_start,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_p
);

  localparam int unsigned CW = (MAXCORR > 0) ? $clog2(MAXCORR + 1) : 1;

  state_e         state, state_nx;
  logic [W-1:0]   a_r, b_r, m3_r;
  logic [2*W-1:0] z_r, t_r, q_ext;
  logic [CW-1:0]  cnt;
  logic           issued, err_r;
  logic [W-1:0]   q, mu;
  logic [7:0]     k;
  logic           accept, done_ok, t_ge_q, can_corr, is_mul;

  barrett_cfg_regs #(.W(W)) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we && (state == IDLE)),
    .cfg_q   (cfg_q),
    .cfg_mu  (cfg_mu),
    .cfg_k   (cfg_k),
    .q       (q),
    .mu      (mu),
    .k       (k),
    .cfg_ok  (cfg_ok),
    .cfg_err (cfg_err)
  );

  // Handshake and status decode; a mul_done is only honoured after this state's start.
  always_comb begin
    is_mul    = (state == MUL_AB) || (state == MUL_MU) || (state == MUL_Q);
    in_ready  = (state == IDLE) && cfg_ok;
    accept    = in_valid && in_ready;
    mul_start = is_mul && !issued;
    done_ok   = is_mul && issued && mul_done;
    q_ext     = {{W{1'b0}}, q};
    t_ge_q    = (t_r >= q_ext);
    can_corr  = (32'(cnt) < MAXCORR);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)                  state_nx = MUL_AB;
      MUL_AB:  if (done_ok)                 state_nx = MUL_MU;
      MUL_MU:  if (done_ok)                 state_nx = MUL_Q;
      MUL_Q:   if (done_ok)                 state_nx = CORR;
      CORR:    if (!(t_ge_q && can_corr))   state_nx = DONE;
      DONE:    if (out_ready)               state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  // Multiplier operand mux and result outputs.
  always_comb begin
    mul_x     = '0;
    mul_y     = '0;
    out_valid = 1'b0;
    out_r     = '0;
    out_err   = 1'b0;
    unique case (state)
      MUL_AB: begin mul_x = a_r;             mul_y = b_r; end
      MUL_MU: begin mul_x = W'(z_r >> k);    mul_y = mu;  end
      MUL_Q:  begin mul_x = m3_r;            mul_y = q;   end
      DONE: begin
        out_valid = 1'b1;
        out_r     = t_r[W-1:0];
        out_err   = err_r;
      end
      default: ;
    endcase
  end

  // Datapath registers: operands, z, m3, t and the correction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      m3_r   <= '0;
      z_r    <= '0;
      t_r    <= '0;
      cnt    <= '0;
      issued <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (state_nx != state) issued <= 1'b0;
      else if (mul_start)    issued <= 1'b1;
      unique case (state)
        IDLE: if (accept) begin
          a_r   <= in_a;
          b_r   <= in_b;
          err_r <= (in_a >= q) || (in_b >= q);
          cnt   <= '0;
        end
        MUL_AB: if (done_ok) z_r  <= mul_p;
        MUL_MU: if (done_ok) m3_r <= W'(mul_p >> k);
        MUL_Q:  if (done_ok) t_r  <= z_r - mul_p;
        CORR: begin
          if (t_ge_q && can_corr) begin
            t_r <= t_r - q_ext;
            cnt <= cnt + CW'(1);
          end else if (t_ge_q) begin
            err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_modmul_ctrl.sv
// Self-checking bench for barrett_modmul_ctrl with a behavioural multiplier.
module tb_barrett_modmul_ctrl;
  localparam int unsigned W = 64;

  logic           clk;
  logic           rst;
  logic           cfg_we;
  logic [W-1:0]   cfg_q, cfg_mu;
  logic [7:0]     cfg_k;
  logic           cfg_ok, cfg_err;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_r;
  logic           out_err;
  logic           mul_start;
  logic [W-1:0]   mul_x, mul_y;
  logic           mul_done;
  logic [2*W-1:0] mul_p;

  barrett_modmul_ctrl #(.W(W), .MAXCORR(2)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_k(cfg_k),
    .cfg_ok(cfg_ok), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int nstart = 0;
  bit auto_mul = 1'b1;
  int lat_lo = 1;
  int lat_hi = 4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Count every multiplier launch.
  initial forever begin
    @(negedge clk);
    if (mul_start) nstart++;
  end

  // Behavioural shared multiplier with random latency.
  initial begin
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(negedge clk);
      if (auto_mul && mul_start && !rst) begin : resp
        logic [W-1:0] x, y;
        int lat;
        x   = mul_x;
        y   = mul_y;
        lat = $urandom_range(lat_hi, lat_lo);
        repeat (lat) @(posedge clk);
        #1;
        check("mul_x_stable", mul_x, x);
        check("mul_y_stable", mul_y, y);
        mul_p    = 128'(x) * 128'(y);
        mul_done = 1'b1;
        @(posedge clk);
        #1;
        mul_done = 1'b0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cfg(input logic [W-1:0] q, input logic [W-1:0] mu, input logic [7:0] k);
    cfg_q  = q;
    cfg_mu = mu;
    cfg_k  = k;
    cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
      timeout("in_ready_wait");
      return;
    end
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] r, output logic e, output bit to);
    int n;
    to = 1'b0;
    r  = '0;
    e  = 1'b0;
    n  = 0;
    while (!out_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      to = 1'b1;
      timeout("out_valid_wait");
      return;
    end
    r = out_r;
    e = out_err;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] r, output logic e, output bit to);
    start_op(a, b, to);
    if (to) return;
    wait_result(r, e, to);
    if (to) return;
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_r", out_r, r);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] mu;
    logic [7:0]   k;
    logic         ok;
  } cfg_vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         err;
    logic         chk_r;
    int           hold;
  } op_vec_t;

  cfg_vec_t cvec[6];
  op_vec_t  ovec[8];

  initial begin : main
    logic [W-1:0] r, q61, mu61, a, b;
    logic [127:0] ref_r;
    logic         e;
    bit           to;
    int           s0, bad;

    cvec[0] = '{64'd97, 64'd168, 8'd7, 1'b1};
    cvec[1] = '{64'hFFFF_FFFF_FFFF_FFC5, 64'd1, 8'd64, 1'b0};
    cvec[2] = '{64'd97, 64'd168, 8'd8, 1'b0};
    cvec[3] = '{64'd0, 64'd168, 8'd7, 1'b0};
    cvec[4] = '{64'd97, 64'd168, 8'd6, 1'b0};
    cvec[5] = '{64'd97, 64'd168, 8'd7, 1'b1};

    ovec[0] = '{64'd50,  64'd60, 64'd90, 1'b0, 1'b1, 5};
    ovec[1] = '{64'd96,  64'd96, 64'd1,  1'b0, 1'b1, 0};
    ovec[2] = '{64'd0,   64'd55, 64'd0,  1'b0, 1'b1, 0};
    ovec[3] = '{64'd45,  64'd77, 64'd70, 1'b0, 1'b1, 0};
    ovec[4] = '{64'd12,  64'd13, 64'd59, 1'b0, 1'b1, 0};
    ovec[5] = '{64'd96,  64'd1,  64'd96, 1'b0, 1'b1, 0};
    ovec[6] = '{64'd100, 64'd5,  64'd0,  1'b1, 1'b0, 5};
    ovec[7] = '{64'd3,   64'd97, 64'd0,  1'b1, 1'b0, 0};

    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_q     = '0;
    cfg_mu    = '0;
    cfg_k     = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_err", out_err, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_x", mul_x, 0);
    check("rst_mul_y", mul_y, 0);
    check("rst_cfg_ok", cfg_ok, 0);
    check("rst_cfg_err", cfg_err, 0);

    for (int i = 0; i < 6; i++) begin
      do_cfg(cvec[i].q, cvec[i].mu, cvec[i].k);
      check("cfg_ok", cfg_ok, cvec[i].ok);
      check("cfg_err", cfg_err, !cvec[i].ok);
      check("cfg_in_ready", in_ready, cvec[i].ok);
    end

    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 8; i++) begin
      s0 = nstart;
      run_op(ovec[i].a, ovec[i].b, ovec[i].hold, r, e, to);
      if (!to) begin
        if (ovec[i].chk_r) check("vec_r", r, ovec[i].r);
        check("vec_err", e, ovec[i].err);
        check("vec_starts", nstart - s0, 3);
      end
    end

    // DONE with out_ready and in_valid together: result retires, new op refused.
    start_op(64'd7, 64'd8, to);
    if (!to) begin
      wait_result(r, e, to);
      if (!to) begin
        check("sim_r", r, 64'd56);
        in_a      = 64'd2;
        in_b      = 64'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sim_out_valid", out_valid, 0);
        check("sim_in_ready", in_ready, 1);
        check("sim_no_start", mul_start, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("sim_still_idle", in_ready, 1);
      end
    end

    // Config write while busy must not disturb the running op or the stored config.
    start_op(64'd50, 64'd60, to);
    if (!to) begin
      do_cfg(64'd0, 64'd0, 8'd7);
      wait_result(r, e, to);
      if (!to) begin
        check("busycfg_r", r, 64'd90);
        check("busycfg_cfg_ok", cfg_ok, 1);
        check("busycfg_cfg_err", cfg_err, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
      end
    end

    // Random operands against plain modular arithmetic.
    q61  = (64'd1 << 61) - 64'd1;
    mu61 = 64'((128'd1 << 122) / 128'(q61));
    do_cfg(q61, mu61, 8'd61);
    check("cfg61_ok", cfg_ok, 1);
    lat_lo = 1;
    lat_hi = 20;
    for (int i = 0; i < 600; i++) begin
      if (i == 0) begin
        a = q61 - 64'd1;
        b = q61 - 64'd1;
      end else if (i == 1) begin
        a = 64'd0;
        b = q61 - 64'd1;
      end else begin
        a = {$urandom, $urandom} % q61;
        b = {$urandom, $urandom} % q61;
      end
      ref_r = (128'(a) * 128'(b)) % 128'(q61);
      s0 = nstart;
      run_op(a, b, 0, r, e, to);
      if (!to) begin
        check("rand_r", r, ref_r);
        check("rand_err", e, 0);
        check("rand_starts", nstart - s0, 3);
      end
    end

    // Reset during MUL_MU followed by a late mul_done.
    do_cfg(64'd97, 64'd168, 8'd7);
    auto_mul = 1'b0;
    start_op(64'd50, 64'd60, to);
    if (!to) begin
      check("ab_start", mul_start, 1);
      check("ab_x", mul_x, 64'd50);
      check("ab_y", mul_y, 64'd60);
      @(posedge clk);
      #1;
      check("ab_start_once", mul_start, 0);
      mul_p    = 128'd3000;
      mul_done = 1'b1;
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      check("mu_start", mul_start, 1);
      check("mu_x", mul_x, 64'd23);
      check("mu_y", mul_y, 64'd168);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("ar_out_valid", out_valid, 0);
      check("ar_out_r", out_r, 0);
      check("ar_out_err", out_err, 0);
      check("ar_mul_start", mul_start, 0);
      check("ar_mul_x", mul_x, 0);
      check("ar_mul_y", mul_y, 0);
      check("ar_in_ready", in_ready, 0);
      check("ar_cfg_ok", cfg_ok, 0);
      check("ar_cfg_err", cfg_err, 0);
      mul_p    = {$urandom, $urandom, $urandom, $urandom};
      mul_done = 1'b1;
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      bad = 0;
      repeat (10) begin
        if (out_valid || mul_start || in_ready) bad++;
        @(posedge clk);
        #1;
      end
      check("ar_no_spurious", bad, 0);
      check("ar_mul_x_idle", mul_x, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
